// File: rtl/octane_spi_pkg.sv
// Shared SPI definitions for the host and the synth target: frame sizes,
// host FSM states and register-number field helpers.
package octane_spi_pkg;

  localparam int SPI_FRAME_BITS  = 32;
  localparam int SPI_SAMPLE_BITS = 16;

  typedef enum logic [2:0] {
    SPI_IDLE,
    SPI_SETUP,
    SPI_SHIFT,
    SPI_HOLD,
    SPI_GAP
  } spi_host_state_t;

  localparam logic [1:0] REG_PREFIX_VOICE_OPERATOR = 2'b11;
  localparam logic [1:0] REG_PREFIX_GLOBAL         = 2'b10;

  // Voice-operator registers: {2'b11, parameter[13:8], voice[7:3], operator[2:0]}
  function automatic logic [15:0] voiceOperatorRegister(
    input logic [5:0] parameterIndex,
    input logic [4:0] voice,
    input logic [2:0] operatorIndex
  );
    return {REG_PREFIX_VOICE_OPERATOR, parameterIndex, voice, operatorIndex};
  endfunction

  function automatic logic [15:0] globalRegister(input logic [13:0] index);
    return {REG_PREFIX_GLOBAL, index};
  endfunction

  function automatic logic isVoiceOperatorRegister(input logic [15:0] registerNumber);
    return registerNumber[15:14] == REG_PREFIX_VOICE_OPERATOR;
  endfunction

  function automatic logic isGlobalRegister(input logic [15:0] registerNumber);
    return registerNumber[15:14] == REG_PREFIX_GLOBAL;
  endfunction

  function automatic logic [5:0] registerParameter(input logic [15:0] registerNumber);
    return registerNumber[13:8];
  endfunction

  function automatic logic [4:0] registerVoice(input logic [15:0] registerNumber);
    return registerNumber[7:3];
  endfunction

  function automatic logic [2:0] registerOperator(input logic [15:0] registerNumber);
    return registerNumber[2:0];
  endfunction

endpackage

// File: rtl/spi_sck_divider.sv
// SCK generator: registered serial clock plus same-cycle rise/fall strobes
// so the host acts on the very edge at which SCK changes.
module spi_sck_divider #(
  parameter int CLOCK_HALF_PERIOD = 4
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic enable,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int DIV_W = (CLOCK_HALF_PERIOD > 1) ? $clog2(CLOCK_HALF_PERIOD) : 1;

  logic [DIV_W-1:0] divCount;
  logic             wrap;

  assign wrap = enable && (divCount == DIV_W'(CLOCK_HALF_PERIOD - 1));
  assign rise = wrap && !sck;
  assign fall = wrap && sck;

  // Disabling clears the divider so every frame starts from a full half-period.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      divCount <= '0;
      sck      <= 1'b0;
    end else if (!enable) begin
      divCount <= '0;
      sck      <= 1'b0;
    end else if (wrap) begin
      divCount <= '0;
      sck      <= !sck;
    end else begin
      divCount <= divCount + 1'b1;
    end
  end

endmodule

// File: rtl/spi_register_host.sv
// SPI mode-0 host: sends one {register number, value} frame per command and
// captures the 16-bit sample the synth returns in the first half of the frame.
module spi_register_host
  import octane_spi_pkg::*;
#(
  parameter int CLOCK_HALF_PERIOD = 4,
  parameter int CS_SETUP_CYCLES   = 2,
  parameter int CS_IDLE_CYCLES    = 4
) (
  input  logic                               i_Clock,
  input  logic                               i_Reset,
  input  logic                               i_Valid,
  output logic                               o_Ready,
  input  logic [15:0]                        i_RegisterNumber,
  input  logic [15:0]                        i_RegisterValue,
  output logic                               o_SPI_CS,
  output logic                               o_SPI_SCK,
  output logic                               o_SPI_MOSI,
  input  logic                               i_SPI_MISO,
  output logic                               o_SampleValid,
  output logic signed [SPI_SAMPLE_BITS-1:0]  o_Sample
);

  localparam int PHASE_MAX = (CS_SETUP_CYCLES > CS_IDLE_CYCLES) ? CS_SETUP_CYCLES : CS_IDLE_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int BIT_W     = $clog2(SPI_FRAME_BITS);

  spi_host_state_t           state;
  logic [PHASE_W-1:0]        phaseCount;
  logic [BIT_W-1:0]          bitCount;
  logic [SPI_FRAME_BITS-1:0] txShift;
  logic [SPI_FRAME_BITS-1:0] rxShift;
  logic                      shiftEnable;
  logic                      sckRise;
  logic                      sckFall;

  assign shiftEnable = (state == SPI_SHIFT);
  // The TX shifter's MSB is the MOSI flop; it drains to zero by the end of a frame.
  assign o_SPI_MOSI  = txShift[SPI_FRAME_BITS-1];

  spi_sck_divider #(
    .CLOCK_HALF_PERIOD(CLOCK_HALF_PERIOD)
  ) sckDivider (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .enable  (shiftEnable),
    .sck     (o_SPI_SCK),
    .rise    (sckRise),
    .fall    (sckFall)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state         <= SPI_IDLE;
      phaseCount    <= '0;
      bitCount      <= '0;
      txShift       <= '0;
      rxShift       <= '0;
      o_SPI_CS      <= 1'b1;
      o_Ready       <= 1'b1;
      o_SampleValid <= 1'b0;
      o_Sample      <= '0;
    end else begin
      o_SampleValid <= 1'b0;
      case (state)
        SPI_IDLE: begin
          if (i_Valid) begin
            txShift    <= {i_RegisterNumber, i_RegisterValue};
            rxShift    <= '0;
            bitCount   <= '0;
            phaseCount <= '0;
            o_SPI_CS   <= 1'b0;
            o_Ready    <= 1'b0;
            state      <= SPI_SETUP;
          end
        end

        SPI_SETUP: begin
          if (phaseCount == PHASE_W'(CS_SETUP_CYCLES - 1)) begin
            phaseCount <= '0;
            state      <= SPI_SHIFT;
          end else begin
            phaseCount <= phaseCount + 1'b1;
          end
        end

        SPI_SHIFT: begin
          if (sckRise) begin
            rxShift  <= {rxShift[SPI_FRAME_BITS-2:0], i_SPI_MISO};
            bitCount <= bitCount + 1'b1;
          end
          // bitCount wraps to zero on the 32nd rise, so a fall seeing zero is the last one.
          if (sckFall) begin
            txShift <= {txShift[SPI_FRAME_BITS-2:0], 1'b0};
            if (bitCount == '0) begin
              state <= SPI_HOLD;
            end
          end
        end

        SPI_HOLD: begin
          if (phaseCount == PHASE_W'(CS_SETUP_CYCLES - 1)) begin
            phaseCount    <= '0;
            o_SPI_CS      <= 1'b1;
            o_SampleValid <= 1'b1;
            o_Sample      <= $signed(rxShift[SPI_FRAME_BITS-1 -: SPI_SAMPLE_BITS]);
            state         <= SPI_GAP;
          end else begin
            phaseCount <= phaseCount + 1'b1;
          end
        end

        SPI_GAP: begin
          if (phaseCount == PHASE_W'(CS_IDLE_CYCLES - 1)) begin
            phaseCount <= '0;
            o_Ready    <= 1'b1;
            state      <= SPI_IDLE;
          end else begin
            phaseCount <= phaseCount + 1'b1;
          end
        end

        default: begin
          o_SPI_CS <= 1'b1;
          o_Ready  <= 1'b1;
          state    <= SPI_IDLE;
        end
      endcase
    end
  end

endmodule
